// File: rtl/i2c_accel_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : i2c_accel_sequencer
// Description : Drives the I2C byte engine to initialise the accelerometer,
//               then periodically reads X/Y/Z and publishes sample sets.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_accel_sequencer #(
   parameter logic [6:0]  DEV_ADDR   = 7'h53,
   parameter int unsigned SAMPLE_DIV = 500000,
   parameter int unsigned MAX_RETRY  = 3
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        enable,
   output logic        cmd_valid,
   input  logic        cmd_ready,
   output logic [6:0]  cmd_dev_addr,
   output logic        cmd_rw,
   output logic [7:0]  cmd_reg,
   output logic [7:0]  cmd_wdata,
   input  logic        rsp_valid,
   input  logic        rsp_nack,
   input  logic [7:0]  rsp_rdata,
   output logic        sample_valid,
   output logic [15:0] accel_x,
   output logic [15:0] accel_y,
   output logic [15:0] accel_z,
   output logic        init_done,
   output logic        error,
   output logic [7:0]  nack_count
);

   localparam int c_TW = $clog2(SAMPLE_DIV + 1);
   localparam int c_RW = $clog2(MAX_RETRY + 2);
   localparam logic [c_TW-1:0] c_DIV_M1    = c_TW'(SAMPLE_DIV - 1);
   localparam logic [c_RW-1:0] c_MAX_RETRY = c_RW'(MAX_RETRY);

   typedef enum logic [2:0] {
      S_IDLE        = 3'd0,
      S_INIT_ISSUE  = 3'd1,
      S_INIT_WAIT   = 3'd2,
      S_PERIOD_WAIT = 3'd3,
      S_READ_ISSUE  = 3'd4,
      S_READ_WAIT   = 3'd5,
      S_PUBLISH     = 3'd6,
      S_ERROR       = 3'd7
   } state_t;

   state_t            r_state, w_state_nxt;
   logic [2:0]        r_idx, w_idx_nxt;
   logic [c_RW-1:0]   r_retry, w_retry_nxt;
   logic [c_TW-1:0]   r_timer, w_timer_nxt;
   logic [7:0]        r_buf [0:4];
   logic [15:0]       r_accel_x, r_accel_y, r_accel_z;
   logic              r_init_done, w_init_done_nxt;
   logic              r_error, w_error_nxt;
   logic [7:0]        r_nack_cnt;
   logic              w_nack_inc, w_buf_we, w_pub, w_burst_start;
   logic              w_timer_due;

   assign w_timer_due = (r_timer >= c_DIV_M1);

   always_comb begin
      w_state_nxt     = r_state;
      w_idx_nxt       = r_idx;
      w_retry_nxt     = r_retry;
      w_timer_nxt     = (r_timer == {c_TW{1'b1}}) ? r_timer : r_timer + c_TW'(1);
      w_init_done_nxt = r_init_done;
      w_error_nxt     = r_error;
      w_nack_inc      = 1'b0;
      w_buf_we        = 1'b0;
      w_pub           = 1'b0;
      w_burst_start   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (enable) begin
               w_idx_nxt   = 3'd0;
               w_retry_nxt = '0;
               if (r_init_done) begin
                  w_state_nxt   = S_READ_ISSUE;
                  w_burst_start = 1'b1;
               end else begin
                  w_state_nxt = S_INIT_ISSUE;
               end
            end
         end
         S_INIT_ISSUE: if (cmd_ready) w_state_nxt = S_INIT_WAIT;
         S_READ_ISSUE: if (cmd_ready) w_state_nxt = S_READ_WAIT;
         S_INIT_WAIT, S_READ_WAIT: begin
            if (rsp_valid) begin
               if (rsp_nack) begin
                  w_nack_inc = 1'b1;
                  if (r_retry < c_MAX_RETRY) begin
                     w_retry_nxt = r_retry + c_RW'(1);
                     // A dropped enable abandons the retry and parks in IDLE.
                     if (!enable)
                        w_state_nxt = S_IDLE;
                     else
                        w_state_nxt = (r_state == S_INIT_WAIT) ? S_INIT_ISSUE : S_READ_ISSUE;
                  end else begin
                     w_error_nxt = 1'b1;
                     w_state_nxt = S_ERROR;
                  end
               end else begin
                  w_retry_nxt = '0;
                  if (r_state == S_INIT_WAIT) begin
                     if (r_idx == 3'd2) begin
                        w_init_done_nxt = 1'b1;
                        w_idx_nxt       = 3'd0;
                        if (enable) begin
                           w_state_nxt   = S_READ_ISSUE;
                           w_burst_start = 1'b1;
                        end else begin
                           w_state_nxt = S_IDLE;
                        end
                     end else begin
                        w_idx_nxt   = r_idx + 3'd1;
                        w_state_nxt = enable ? S_INIT_ISSUE : S_IDLE;
                     end
                  end else begin
                     w_buf_we = 1'b1;
                     if (!enable) begin
                        w_state_nxt = S_IDLE;
                     end else if (r_idx == 3'd5) begin
                        w_pub       = 1'b1;
                        w_idx_nxt   = 3'd0;
                        w_state_nxt = S_PUBLISH;
                     end else begin
                        w_idx_nxt   = r_idx + 3'd1;
                        w_state_nxt = S_READ_ISSUE;
                     end
                  end
               end
            end
         end
         S_PUBLISH: begin
            // An overrun burst restarts straight away instead of waiting.
            if (enable && w_timer_due) begin
               w_state_nxt   = S_READ_ISSUE;
               w_burst_start = 1'b1;
            end else begin
               w_state_nxt = S_PERIOD_WAIT;
            end
         end
         S_PERIOD_WAIT: begin
            if (!enable) begin
               w_state_nxt = S_IDLE;
            end else if (w_timer_due) begin
               w_state_nxt   = S_READ_ISSUE;
               w_burst_start = 1'b1;
            end
         end
         S_ERROR: begin
            if (!enable) begin
               w_state_nxt     = S_IDLE;
               w_error_nxt     = 1'b0;
               w_init_done_nxt = 1'b0;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
      if (w_burst_start) w_timer_nxt = '0;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= S_IDLE;
         r_idx       <= 3'd0;
         r_retry     <= '0;
         r_timer     <= '0;
         r_init_done <= 1'b0;
         r_error     <= 1'b0;
         r_nack_cnt  <= 8'd0;
         r_accel_x   <= 16'd0;
         r_accel_y   <= 16'd0;
         r_accel_z   <= 16'd0;
         for (int i = 0; i < 5; i++) r_buf[i] <= 8'd0;
      end else begin
         r_state     <= w_state_nxt;
         r_idx       <= w_idx_nxt;
         r_retry     <= w_retry_nxt;
         r_timer     <= w_timer_nxt;
         r_init_done <= w_init_done_nxt;
         r_error     <= w_error_nxt;
         if (w_nack_inc && (r_nack_cnt != 8'hFF))
            r_nack_cnt <= r_nack_cnt + 8'd1;
         if (w_buf_we && (r_idx < 3'd5))
            r_buf[r_idx] <= rsp_rdata;
         // Last byte bypasses the shadow buffer so all axes land together.
         if (w_pub) begin
            r_accel_x <= {r_buf[1], r_buf[0]};
            r_accel_y <= {r_buf[3], r_buf[2]};
            r_accel_z <= {rsp_rdata, r_buf[4]};
         end
      end
   end

   always_comb begin
      cmd_valid    = 1'b0;
      cmd_dev_addr = 7'd0;
      cmd_rw       = 1'b0;
      cmd_reg      = 8'd0;
      cmd_wdata    = 8'd0;
      case (r_state)
         S_INIT_ISSUE: begin
            cmd_valid    = 1'b1;
            cmd_dev_addr = DEV_ADDR;
            case (r_idx)
               3'd0:    begin cmd_reg = 8'h2C; cmd_wdata = 8'h0A; end
               3'd1:    begin cmd_reg = 8'h31; cmd_wdata = 8'h0B; end
               default: begin cmd_reg = 8'h2D; cmd_wdata = 8'h08; end
            endcase
         end
         S_READ_ISSUE: begin
            cmd_valid    = 1'b1;
            cmd_dev_addr = DEV_ADDR;
            cmd_rw       = 1'b1;
            cmd_reg      = 8'h32 + {5'd0, r_idx};
         end
         default: ;
      endcase
   end

   assign sample_valid = (r_state == S_PUBLISH);
   assign accel_x      = r_accel_x;
   assign accel_y      = r_accel_y;
   assign accel_z      = r_accel_z;
   assign init_done    = r_init_done;
   assign error        = r_error;
   assign nack_count   = r_nack_cnt;

endmodule
`default_nettype wire
